// File: rtl/line_clear_engine.sv
// Line-clear sequencer for the 20x10 playfield: scans rows bottom-up over a single-cell
// grid port, compacts surviving rows downward, zero-fills the top and reports the count.
module line_clear_engine #(
  parameter int ROWS = 20,
  parameter int COLS = 10,
  parameter int X_W  = 4,
  parameter int Y_W  = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic [4:0]     lines_cleared,
  output logic [X_W-1:0] gx,
  output logic [Y_W-1:0] gy,
  output logic           g_rd_en,
  output logic           g_wr_en,
  output logic           g_wr_data,
  input  logic           g_rd_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CLEAR = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [X_W-1:0] COL_LAST = X_W'(COLS - 1);
  localparam logic [Y_W-1:0] ROW_LAST = Y_W'(ROWS - 1);

  logic [2:0]      state_q, state_d;
  logic [Y_W-1:0]  src_q, src_d;
  logic [Y_W-1:0]  dst_q, dst_d;
  logic [X_W-1:0]  col_q, col_d;
  logic [COLS-1:0] row_buf_q, row_buf_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [4:0]      lines_q, lines_d;

  logic            col_last;
  logic            row_full;
  logic            row_done;
  logic            clear_last;

  assign col_last   = (col_q == COL_LAST);
  assign row_full   = &row_buf_q;
  // Zero-fill walks rows 0 .. cnt-1 top-down; this marks the final one.
  assign clear_last = (src_q == Y_W'(cnt_q - 5'd1));

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    col_d     = col_q;
    row_buf_d = row_buf_q;
    cnt_d     = cnt_q;
    lines_d   = lines_q;
    row_done  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d     = ROW_LAST;
          dst_d     = ROW_LAST;
          col_d     = '0;
          cnt_d     = '0;
          lines_d   = '0;
          row_buf_d = '0;
          state_d   = S_READ;
        end
      end

      S_READ: begin
        row_buf_d[col_q] = g_rd_data;
        if (col_last) begin
          col_d   = '0;
          state_d = S_EVAL;
        end else begin
          col_d = col_q + X_W'(1);
        end
      end

      S_EVAL: begin
        if (row_full) begin
          cnt_d    = cnt_q + 5'd1;
          row_done = 1'b1;
        end else if (dst_q != src_q) begin
          state_d = S_WRITE;
        end else begin
          dst_d    = dst_q - Y_W'(1);
          row_done = 1'b1;
        end
      end

      S_WRITE: begin
        if (col_last) begin
          col_d    = '0;
          dst_d    = dst_q - Y_W'(1);
          row_done = 1'b1;
        end else begin
          col_d = col_q + X_W'(1);
        end
      end

      S_CLEAR: begin
        if (col_last) begin
          col_d = '0;
          if (clear_last) begin
            state_d = S_DONE;
          end else begin
            src_d = src_q + Y_W'(1);
          end
        end else begin
          col_d = col_q + X_W'(1);
        end
      end

      S_DONE: begin
        lines_d = cnt_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Row bookkeeping shared by EVAL and WRITE; cnt_d already includes a row cleared this cycle.
    if (row_done) begin
      if (src_q == '0) begin
        src_d   = '0;
        state_d = (cnt_d != 5'd0) ? S_CLEAR : S_DONE;
      end else begin
        src_d   = src_q - Y_W'(1);
        state_d = S_READ;
      end
    end
  end

  always_comb begin
    gx        = '0;
    gy        = '0;
    g_rd_en   = 1'b0;
    g_wr_en   = 1'b0;
    g_wr_data = 1'b0;

    case (state_q)
      S_READ: begin
        g_rd_en = 1'b1;
        gy      = src_q;
        gx      = col_q;
      end
      S_WRITE: begin
        g_wr_en   = 1'b1;
        gy        = dst_q;
        gx        = col_q;
        g_wr_data = row_buf_q[col_q];
      end
      S_CLEAR: begin
        g_wr_en = 1'b1;
        gy      = src_q;
        gx      = col_q;
      end
      default: begin
        gx = '0;
      end
    endcase
  end

  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign lines_cleared = lines_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      col_q     <= '0;
      row_buf_q <= '0;
      cnt_q     <= '0;
      lines_q   <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      col_q     <= col_d;
      row_buf_q <= row_buf_d;
      cnt_q     <= cnt_d;
      lines_q   <= lines_d;
    end
  end

endmodule

// File: tb/tb_line_clear_engine.sv
// Directed bench for line_clear_engine: a behavioural grid + compaction model, a per-cycle
// port-rule monitor and hand-computed expectations for each scenario.
module tb_line_clear_engine;

  localparam int ROWS = 20;
  localparam int COLS = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done;
  logic [4:0] lines_cleared;
  logic [3:0] gx;
  logic [4:0] gy;
  logic       g_rd_en, g_wr_en, g_wr_data;
  logic       g_rd_data;

  line_clear_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .lines_cleared(lines_cleared),
    .gx(gx), .gy(gy), .g_rd_en(g_rd_en), .g_wr_en(g_wr_en),
    .g_wr_data(g_wr_data), .g_rd_data(g_rd_data)
  );

  always #5 clk = ~clk;

  // Grid memory: bit x of grid[y] is column x.
  logic [9:0] grid      [ROWS];
  logic [9:0] init_rows [ROWS];
  logic [9:0] exp_grid  [ROWS];
  logic       load_req = 1'b0;

  always_comb begin
    g_rd_data = 1'b0;
    if (g_rd_en && gy < 5'(ROWS) && gx < 4'(COLS)) g_rd_data = grid[gy][gx];
  end

  always @(posedge clk) begin
    if (load_req) begin
      for (int y = 0; y < ROWS; y++) grid[y] <= init_rows[y];
    end else if (g_wr_en && gy < 5'(ROWS) && gx < 4'(COLS)) begin
      grid[gy][gx] <= g_wr_data;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  int n_rd = 0;
  int n_wr = 0;
  int exp_lines, exp_done, exp_wr;

  task automatic chk(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Per-cycle port-rule monitor plus read/write counting.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        vectors++;
        if ((g_rd_en && g_wr_en) ||
            (!busy && (done || g_rd_en || g_wr_en || g_wr_data || gx != 0 || gy != 0)) ||
            ((g_rd_en || g_wr_en) && (gy >= 5'(ROWS) || gx >= 4'(COLS)))) begin
          miscompares++;
          $display("FAIL port_rules t=%0t: actual rd=%b wr=%b busy=%b done=%b gx=%0d gy=%0d wd=%b required legal port state",
                   $time, g_rd_en, g_wr_en, busy, done, gx, gy, g_wr_data);
        end
        if (g_rd_en) n_rd++;
        if (g_wr_en) n_wr++;
      end
    end
  end

  task automatic clear_init();
    for (int y = 0; y < ROWS; y++) init_rows[y] = '0;
  endtask

  task automatic load_grid();
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  // Compaction model: drop full rows, stack the rest at the bottom in order, zero the top.
  task automatic model();
    int d, cnt, moved;
    bit seen_full;
    d = ROWS - 1; cnt = 0; moved = 0; seen_full = 0;
    for (int y = ROWS - 1; y >= 0; y--) begin
      if (grid[y] == 10'h3FF) begin
        cnt++;
        seen_full = 1;
      end else begin
        exp_grid[d] = grid[y];
        d--;
        if (seen_full) moved++;
      end
    end
    for (int y = 0; y <= d; y++) exp_grid[y] = '0;
    exp_lines = cnt;
    exp_wr    = 10 * (moved + cnt);
    exp_done  = 220 + 10 * moved + 10 * cnt + 1;
  endtask

  // Called at a negedge; asserts start for the following edge and waits for done.
  task automatic run_scan(input int pulse1, input int pulse2, input int abort_at, output int done_cyc);
    n_rd = 0;
    n_wr = 0;
    done_cyc = -1;
    start = 1'b1;
    for (int c = 1; c <= 2000; c++) begin
      @(negedge clk);
      start = (c == pulse1 || c == pulse2);
      if (c == 1) begin
        chk("busy_after_start", int'(busy), 1);
        chk("lines_reset_on_start", int'(lines_cleared), 0);
      end
      if (c == abort_at) begin
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("outputs_in_reset",
            int'({busy, done, lines_cleared, gx, gy, g_rd_en, g_wr_en, g_wr_data}), 0);
        return;
      end
      if (done) begin
        done_cyc = c;
        start = 1'b0;
        break;
      end
    end
    if (done_cyc < 0) begin
      start = 1'b0;
      chk("done_timeout", done_cyc, exp_done);
    end
  endtask

  task automatic post_checks(input string tag, input int done_cyc);
    @(negedge clk);
    chk({tag, "_busy_dropped"}, int'(busy), 0);
    chk({tag, "_lines"}, int'(lines_cleared), exp_lines);
    chk({tag, "_done_cycle"}, done_cyc, exp_done);
    chk({tag, "_writes"}, n_wr, exp_wr);
    chk({tag, "_reads"}, n_rd, ROWS * COLS);
    for (int y = 0; y < ROWS; y++) chk({tag, "_row"}, int'(grid[y]), int'(exp_grid[y]));
    $display("run %s: done in cycle %0d, lines_cleared=%0d, writes=%0d", tag, done_cyc, lines_cleared, n_wr);
  endtask

  initial begin
    int d, d2;

    clear_init();
    rst_n = 1'b0;
    load_req = 1'b1;
    repeat (3) @(negedge clk);
    load_req = 1'b0;
    chk("reset_state", int'({busy, done, lines_cleared, gx, gy, g_rd_en, g_wr_en, g_wr_data}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Empty grid
    clear_init();
    load_grid();
    model();
    run_scan(0, 0, 0, d);
    post_checks("empty", d);
    chk("empty_done_literal", d, 221);
    chk("empty_lines_literal", int'(lines_cleared), 0);
    chk("empty_no_writes", n_wr, 0);

    // Bottom row full
    clear_init();
    init_rows[19] = 10'h3FF;
    init_rows[18] = 10'b1000000001;
    init_rows[0]  = 10'b0000000001;
    load_grid();
    model();
    run_scan(0, 0, 0, d);
    post_checks("one", d);
    chk("one_done_literal", d, 421);
    chk("one_lines_literal", int'(lines_cleared), 1);
    chk("one_row19_literal", int'(grid[19]), 10'b1000000001);
    chk("one_row1_literal", int'(grid[1]), 10'b0000000001);
    chk("one_row0_literal", int'(grid[0]), 0);

    // Two separated full rows
    clear_init();
    init_rows[19] = 10'h3FF;
    init_rows[18] = 10'b0101010101;
    init_rows[17] = 10'h3FF;
    init_rows[16] = 10'b0011001100;
    load_grid();
    model();
    run_scan(0, 0, 0, d);
    post_checks("two", d);
    chk("two_lines_literal", int'(lines_cleared), 2);
    chk("two_row19_literal", int'(grid[19]), 10'b0101010101);
    chk("two_row18_literal", int'(grid[18]), 10'b0011001100);
    chk("two_row1_literal", int'(grid[1]), 0);
    chk("two_row0_literal", int'(grid[0]), 0);

    // Four stacked full rows
    clear_init();
    for (int y = 16; y < 20; y++) init_rows[y] = 10'h3FF;
    init_rows[15] = 10'b1111111110;
    load_grid();
    model();
    run_scan(0, 0, 0, d);
    post_checks("four", d);
    chk("four_lines_literal", int'(lines_cleared), 4);
    chk("four_row19_literal", int'(grid[19]), 10'b1111111110);
    for (int y = 0; y < 4; y++) chk("four_top_zero_literal", int'(grid[y]), 0);

    // start re-pulsed mid-run, then accepted in the first IDLE cycle
    clear_init();
    init_rows[19] = 10'h3FF;
    init_rows[18] = 10'b1000000001;
    init_rows[0]  = 10'b0000000001;
    load_grid();
    model();
    run_scan(5, 300, 0, d);
    post_checks("repulse", d);
    chk("repulse_done_literal", d, 421);
    model();
    run_scan(0, 0, 0, d2);
    post_checks("restart", d2);
    chk("restart_done_literal", d2, 221);

    // Reset during WRITE (row 17 moving into row 18, column 6)
    clear_init();
    init_rows[19] = 10'h3FF;
    init_rows[18] = 10'b1000000001;
    init_rows[0]  = 10'b0000000001;
    load_grid();
    model();
    run_scan(0, 0, 50, d);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_row19_literal", int'(grid[19]), 10'b1000000001);
    chk("abort_row18_literal", int'(grid[18]), 10'b1000000000);
    model();
    run_scan(0, 0, 0, d);
    post_checks("after_abort", d);
    chk("after_abort_done_literal", d, 221);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/line_clear_engine.md
# line_clear_engine

Sequential controller that drives the playfield grid's single-cell read/write port to find and remove completed rows. After a piece locks, the game logic pulses `start`. The engine then scans the 20x10 grid bottom-up, drops every surviving row down over the cleared ones, zero-fills the vacated top rows, and reports how many lines were cleared. It sits between the game FSM and the grid memory, and it owns the grid port while `busy` is high.

## Interface
- `ROWS`, 20, number of grid rows (y = 0 is the top row, y = ROWS-1 is the bottom row)
- `COLS`, 10, number of grid columns
- `X_W`, 4, column index width
- `Y_W`, 5, row index width
- `clk`  in  1  single system clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous and active-low; aborts any operation
- `start`  in  1  one-cycle request to begin a scan; sampled only in IDLE
- `busy`  out  1  high from the cycle after `start` is accepted through the DONE cycle
- `done`  out  1  one-cycle pulse in the DONE state
- `lines_cleared`  out  5  number of full rows removed (0..20); held until the next accepted `start`
- `gx`  out  X_W  grid column address
- `gy`  out  Y_W  grid row address
- `g_rd_en`  out  1  grid read enable
- `g_wr_en`  out  1  grid write enable
- `g_wr_data`  out  1  cell value to write
- `g_rd_data`  in  1  grid cell value; combinational from (`gy`,`gx`) while `g_rd_en` is high

## Operation
- Internal state:
  - `src` row pointer and `dst` row pointer, both Y_W bits
  - `col` counter, X_W bits
  - `row_buf` register, COLS bits
  - `cnt` lines counter, 5 bits
- FSM states: IDLE, READ, EVAL, WRITE, CLEAR, DONE.
- IDLE, with `start` high:
  - `src` = `dst` = ROWS-1, `col` = 0, `cnt` = 0, `lines_cleared` = 0.
  - Go to READ.
- READ:
  - Drive `g_rd_en`=1, `gy`=`src`, `gx`=`col`.
  - Capture `row_buf[col]` <= `g_rd_data` on the clock edge.
  - After `col` = COLS-1: `col` <= 0, go to EVAL.
- EVAL (one cycle, no grid access):
  - If `&row_buf`: `cnt` <= `cnt`+1; `dst` is unchanged; the row is finished.
  - Else if `dst` != `src`: go to WRITE.
  - Else: `dst` <= `dst`-1; the row is finished.
- WRITE:
  - Drive `g_wr_en`=1, `gy`=`dst`, `gx`=`col`, `g_wr_data`=`row_buf[col]`.
  - After `col` = COLS-1: `dst` <= `dst`-1; the row is finished.
- Row finished:
  - If `src` = 0: go to CLEAR with `src` <= 0 if `cnt` > 0, else go to DONE.
  - Otherwise: `src` <= `src`-1 and go to READ.
  - The decrement to `src` = 0 must not wrap before this test.
- CLEAR:
  - Drive `g_wr_en`=1, `g_wr_data`=0, `gy`=`src`, `gx`=`col`.
  - This zero-fills rows 0 .. `cnt`-1.
  - After the last column of row `cnt`-1: go to DONE.
- DONE:
  - `done`=1, `busy`=1, `lines_cleared` <= `cnt`.
  - Next cycle: IDLE.
- Port rules:
  - `g_rd_en` and `g_wr_en` are never high together.
  - Outside READ/WRITE/CLEAR: `gx`=0, `gy`=0, `g_wr_data`=0, both enables 0.
- `start` while not in IDLE is ignored; it is neither queued nor restarting.
- `dst` is never decremented below 0. When `dst` = 0 it is decremented only on the final row, where the value is unused.
- Reset (`rst_n` low, at any time including mid-WRITE/CLEAR):
  - State IDLE.
  - All outputs 0, including `busy`, `done`, `lines_cleared`, `gx`, `gy`, enables and `g_wr_data`.
  - All pointers and `row_buf` cleared.
  - Grid contents are left as-is; the grid has its own reset.

## Timing
- Cycle numbering: cycle 1 is the first cycle after the edge that samples `start`.
- Per-row cost:
  - READ: 10 cycles.
  - EVAL: 1 cycle.
  - WRITE: +10 cycles when the row moves.
  - CLEAR: 10 cycles per cleared line.
- No full rows: 20 x 11 = 220 cycles, no writes, `done` in cycle 221.
- Bottom row only full: 11 + 19 x 21 + 10 = 420 cycles, `done` in cycle 421.
- General latency: 220 + 10 x (rows moved) + 10 x `cnt` + 1 cycles to `done`.
- Rows moved = rows above the lowest full row that are themselves not full.
- `busy` drops the cycle after `done`. A `start` in that same IDLE cycle is accepted.

## Test plan
- Empty grid, `start` pulse:
  - `done` in cycle 221, `lines_cleared`=0.
  - `g_wr_en` never high.
  - Grid unchanged.
- Row 19 full; row 18 = 1000000001; row 0 = 0000000001; others empty:
  - `lines_cleared`=1, `done` in cycle 421.
  - Row 19 = 1000000001, row 1 = 0000000001, row 0 all 0.
- Rows 19 and 17 full; row 18 = 0101010101; row 16 = 0011001100:
  - `lines_cleared`=2.
  - Row 19 = 0101010101, row 18 = 0011001100, rows 0-1 zero.
- Rows 16-19 full; row 15 = 1111111110; the rest empty:
  - `lines_cleared`=4.
  - Row 19 = 1111111110, rows 0-3 zero.
  - Checker confirms `g_rd_en` and `g_wr_en` are never both high.
- `start` re-pulsed at cycles 5 and 300 of a 1-line clear:
  - Ignored, `done` still in cycle 421.
  - A `start` in the first IDLE cycle is accepted: `busy`=1 next cycle, `lines_cleared` reset to 0.
- `rst_n` low for 1 cycle during WRITE (around cycle 50):
  - All outputs 0 immediately, FSM in IDLE.
  - A subsequent `start` runs a full scan from row 19 correctly.
